// File: rtl/cordic_pkg.sv
// Shared types, gain constants and angle tables for the multi-mode CORDIC engine.
// All constants are Q16.16.
package cordic_pkg;

   typedef enum logic [1:0] {
      M_CIRC = 2'd0,
      M_HYP  = 2'd1,
      M_EXP  = 2'd2,
      M_VEC  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ROT,
      S_POST,
      S_DONE
   } state_e;

   localparam int K         = 39797;
   localparam int KH_INV    = 79134;
   localparam int PI        = 205887;
   localparam int HALF_PI   = 102944;
   localparam int ATANH_MAX = 73283;

   // atan(2^-i), i = 0..23
   localparam int ATAN_TAB [0:23] = '{
      51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
      256, 128, 64, 32, 16, 8, 4, 2,
      1, 0, 0, 0, 0, 0, 0, 0
   };

   // atanh(2^-i), stored at i-1 for i = 1..24
   localparam int ATANH_TAB [0:23] = '{
      35999, 16739, 8235, 4101, 2049, 1024, 512, 256,
      128, 64, 32, 16, 8, 4, 2, 1,
      0, 0, 0, 0, 0, 0, 0, 0
   };

endpackage

// File: rtl/cordic_engine_mc_rom.sv
// Combinational micro-rotation angle lookup: atan(2^-idx) or atanh(2^-idx).
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [4:0]               idx,
   input  logic                     hyp,
   output logic signed [DATA_W-1:0] ang
);

   always_comb begin
      ang = '0;
      if (hyp) begin
         if (idx >= 5'd1 && idx <= 5'd24)
            ang = DATA_W'(ATANH_TAB[idx - 5'd1]);
      end else if (idx <= 5'd23) begin
         ang = DATA_W'(ATAN_TAB[idx]);
      end
   end

endmodule

// File: rtl/cordic_engine_mc.sv
// Iterative multi-mode Q16.16 CORDIC: sin/cos, sinh/cosh, exp, magnitude/atan2.
// Optional CORDIC_RANGE_CHK_EN flags hyperbolic arguments outside convergence.
module cordic_engine_mc
   import cordic_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ITER   = 16,
   parameter int TAG_W  = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic [DATA_W-1:0] in_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_r1,
   output logic [DATA_W-1:0] out_r2,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic              busy
);

   localparam int W  = DATA_W + 2;
   localparam int PW = W + 18;

   localparam logic signed [W-1:0]  PI_W      = W'(PI);
   localparam logic signed [W-1:0]  HALF_PI_W = W'(HALF_PI);
   localparam logic signed [W-1:0]  K_W       = W'(K);
   localparam logic signed [W-1:0]  KH_W      = W'(KH_INV);
   localparam logic signed [PW-1:0] KC        = PW'(K);
   localparam logic signed [PW-1:0] RND       = PW'(32768);

   state_e state_q, state_d;
   mode_e  mode_q;

   logic [TAG_W-1:0]    tag_q;
   logic signed [W-1:0] x_q, y_q, z_q;
   logic [4:0]          idx_q;
   logic                rep_q, neg_q, zero_q;

   logic                hyp, vec, rep_go, last_rot, d_pos;
   logic signed [DATA_W-1:0] rom_ang;
   logic signed [W-1:0] ang_w, xs, ys;
   logic signed [W-1:0] rot_x, rot_y, rot_z;
   logic signed [W-1:0] pre_x, pre_y, pre_z;
   logic                pre_neg, pre_zero;
   logic signed [PW-1:0] prod_r;
   logic [DATA_W-1:0]   mag, r1_d, r2_d;
   logic                unused_prod;

   assign hyp = (mode_q == M_HYP) || (mode_q == M_EXP);
   assign vec = (mode_q == M_VEC);

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

   cordic_atan_rom #(
      .DATA_W (DATA_W)
   ) u_rom (
      .idx (idx_q),
      .hyp (hyp),
      .ang (rom_ang)
   );

   assign ang_w = W'(rom_ang);

   // Hyperbolic indices 4 and 13 run twice for convergence
   assign rep_go   = hyp && !rep_q &&
                     (idx_q == 5'd4 || idx_q == 5'd13);
   assign last_rot = hyp ? (idx_q == 5'(ITER) && !rep_go)
                         : (idx_q == 5'(ITER - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid) state_d = S_PRE;
         S_PRE:  state_d = S_ROT;
         S_ROT:  if (last_rot) state_d = S_POST;
         S_POST: state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      pre_x    = x_q;
      pre_y    = y_q;
      pre_z    = z_q;
      pre_neg  = 1'b0;
      pre_zero = 1'b0;
      unique case (mode_q)
         M_CIRC: begin
            pre_x = K_W;
            pre_y = '0;
            if (z_q > HALF_PI_W) begin
               pre_z   = z_q - PI_W;
               pre_neg = 1'b1;
            end else if (z_q < -HALF_PI_W) begin
               pre_z   = z_q + PI_W;
               pre_neg = 1'b1;
            end
         end
         M_HYP, M_EXP: begin
            pre_x = KH_W;
            pre_y = '0;
         end
         M_VEC: begin
            pre_zero = (x_q == '0) && (y_q == '0);
            pre_z    = '0;
            if (x_q[W-1]) begin
               pre_x = -x_q;
               pre_y = -y_q;
               pre_z = y_q[W-1] ? -PI_W : PI_W;
            end
         end
      endcase
   end

   always_comb begin
      xs    = x_q >>> idx_q;
      ys    = y_q >>> idx_q;
      d_pos = vec ? y_q[W-1] : ~z_q[W-1];
      if (d_pos) begin
         rot_x = hyp ? x_q + ys : x_q - ys;
         rot_y = y_q + xs;
         rot_z = z_q - ang_w;
      end else begin
         rot_x = hyp ? x_q - ys : x_q + ys;
         rot_y = y_q - xs;
         rot_z = z_q + ang_w;
      end
   end

   // Undo the circular vectoring gain with a rounded constant multiply
   assign prod_r      = PW'(x_q) * KC + RND;
   assign mag         = prod_r[DATA_W+15:16];
   assign unused_prod = ^{prod_r[15:0], prod_r[PW-1:DATA_W+16]};

   always_comb begin
      r1_d = DATA_W'(y_q);
      r2_d = DATA_W'(x_q);
      unique case (mode_q)
         M_CIRC: if (neg_q) begin
            r1_d = DATA_W'(-y_q);
            r2_d = DATA_W'(-x_q);
         end
         M_HYP: ;
         M_EXP: begin
            r1_d = DATA_W'(x_q + y_q);
            r2_d = DATA_W'(x_q - y_q);
         end
         M_VEC: begin
            r1_d = mag;
            r2_d = zero_q ? '0 : DATA_W'(z_q);
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mode_q  <= M_CIRC;
         tag_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         rep_q   <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
         out_r1  <= '0;
         out_r2  <= '0;
         out_tag <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: if (in_valid) begin
               mode_q <= mode_e'(in_mode);
               tag_q  <= in_tag;
               x_q    <= W'($signed(in_x));
               y_q    <= W'($signed(in_y));
               z_q    <= W'($signed(in_z));
               idx_q  <= (in_mode == 2'd1 || in_mode == 2'd2)
                         ? 5'd1 : 5'd0;
               rep_q  <= 1'b0;
            end
            S_PRE: begin
               x_q    <= pre_x;
               y_q    <= pre_y;
               z_q    <= pre_z;
               neg_q  <= pre_neg;
               zero_q <= pre_zero;
            end
            S_ROT: begin
               x_q <= rot_x;
               y_q <= rot_y;
               z_q <= rot_z;
               if (rep_go) begin
                  rep_q <= 1'b1;
               end else begin
                  rep_q <= 1'b0;
                  idx_q <= idx_q + 5'd1;
               end
            end
            S_POST: begin
               out_r1  <= r1_d;
               out_r2  <= r2_d;
               out_tag <= tag_q;
            end
            default: ;
         endcase
      end
   end

`ifdef CORDIC_RANGE_CHK_EN
   localparam logic signed [W-1:0] ATANH_MAX_W = W'(ATANH_MAX);
   logic err_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         err_q <= 1'b0;
      else if (state_q == S_PRE)
         err_q <= hyp && (z_q > ATANH_MAX_W || z_q < -ATANH_MAX_W);
   end

   assign out_err = (state_q == S_DONE) && err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: doc/cordic_engine_mc.md
Name: cordic_engine_mc

Overview:
Iterative multi-mode CORDIC engine, generalised successor to the fixed-mode CORDIC path in signal_analyzer_top.
- Q16.16 fixed point, one micro-rotation per clock.
- Four functions: sin/cos, sinh/cosh, exp/exp⁻¹, magnitude/atan2.
- Full-circle angle pre-rotation, tagged requests, valid/ready handshake both sides.
- Sits between ADC-derived operand logic and UART/HDMI result formatters in the clk_100m domain.

Parameters:
- DATA_W, 32, operand/result width, signed Q(DATA_W-16).16.
- ITER, 16, micro-rotation count (legal 8..24).
- TAG_W, 2, request tag width (e.g. channel id), echoed unchanged.

Ports:
- sys_clk  in  1  clock, clk_100m domain.
- sys_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- in_mode  in  2  0=sin/cos, 1=sinh/cosh, 2=exp, 3=vectoring.
- in_tag  in  TAG_W  request tag.
- in_x  in  DATA_W  vectoring x (ignored in modes 0-2).
- in_y  in  DATA_W  vectoring y (ignored in modes 0-2).
- in_z  in  DATA_W  angle in rad, or hyperbolic argument (modes 0-2).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_r1  out  DATA_W  sin / sinh / e^z / magnitude.
- out_r2  out  DATA_W  cos / cosh / e^-z / atan2(y,x).
- out_tag  out  TAG_W  echoed tag.
- out_err  out  1  argument out of convergence range.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, in_ready=1; out_valid, out_r1, out_r2, out_tag, out_err, busy = 0.
- Reset mid-operation: aborts immediately; no result is emitted.
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, latch operands, mode and tag; go to PRE.
  - PRE (1 cycle):
    - Mode 0: if |z|>π/2, z -= sign(z)·π and set negate flag. x0=K=39797, y0=0.
    - Modes 1/2: x0=1/Kh=79134, y0=0.
    - Mode 3: if x<0, (x,y) = (-x,-y), z0=±π by sign(y), else z0=0.
  - ROT: one micro-rotation per cycle.
    - Circular: indices i=0..ITER-1.
    - Hyperbolic: indices i=1..ITER, indices 4 and 13 repeated when ≤ITER.
    - Direction d=sign(z) in rotation modes, d=-sign(y) in vectoring.
    - Shifts are arithmetic; atan/atanh constants come from ROM, Q16.16.
  - POST (1 cycle):
    - Mode 0: apply negate flag to both outputs.
    - Mode 2: r1=x+y, r2=x-y.
    - Mode 3: r1 = x·K via constant multiply, bits [47:16] rounded.
  - DONE: out_valid=1, outputs held stable until out_valid&out_ready, then go to IDLE.
- in_ready is 1 only in IDLE, so there is never more than one request in flight.
- Latency (accept edge to out_valid):
  - Circular modes: ITER+2.
  - Hyperbolic modes: ITER+2+R, R = count of {4,13} ≤ ITER (R=2 at default).
- Next acceptance is earliest on the cycle after the out handshake.
- Width rules:
  - Internal x/y/z carry 2 guard bits; outputs are truncated to DATA_W with wrap.
  - Exp overflow beyond the DATA_W range is the caller's concern.
- Boundaries:
  - z=±π exactly takes the pre-rotation path.
  - In_x=in_y=0 in vectoring: r1=0, r2=0.
  - ITER counter wraps only through the IDLE reload.

Optional Feature:
- Macro CORDIC_RANGE_CHK_EN.
- Defined: in PRE, modes 1/2 with |z|>1.1182 (73283) set out_err=1 with the result. Computation still proceeds; out_err clears on the out handshake.
- Undefined: no comparator; out_err is tied to 0.

Decomposition:
- Package cordic_pkg:
  - Mode enum and FSM state enum.
  - Constants K=39797, KH_INV=79134, PI=205887, HALF_PI=102944, ATANH_MAX=73283.
  - atan and atanh constant tables for index 0..23.
- One sub-module, cordic_atan_rom: combinational lookup, inputs index and hyperbolic select, output DATA_W angle constant.

Test Plan:
- Mode 0, z=0: out_r1=0, out_r2=65536 (±8 LSB), out_valid exactly 18 cycles after accept.
- Mode 0, z=51472 (π/4): r1=r2=46341 ±8. Then z=-205887 (-π): r1≈0, r2=-65536 ±8 (pre-rotation path).
- Mode 2, z=32768 (0.5): r1=108051, r2=39750 ±16, latency 20. Mode 1 same z: r1=34152, r2=73897. With CORDIC_RANGE_CHK_EN, z=98304 (1.5) sets out_err=1.
- Mode 3, x=196608, y=262144 (3,4): r1=327680, r2=60771 ±16. Then x=-65536, y=0: r2=+205887.
- Backpressure: out_ready=0 for 50 cycles. Outputs and tag 2'b10 stay stable; in_ready stays 0; new in_valid is ignored and accepted only after the handshake.
- Assert sys_rst at ROT cycle 7: all outputs 0 next edge, no stale out_valid. A post-reset request completes correctly.
